// File: rtl/internet_pkg.sv
// internet_pkg
//   Shared types and constants for the internet link scheduler.
//   - state_e     : scheduler FSM state (IDLE / GRANT / GUARD)
//   - DST_*       : destination indices, also the internet_demux Sel encoding
//   - onehot4()   : destination index -> one-hot grant vector
package internet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_e;

  localparam logic [1:0] DST_LIB    = 2'd0;
  localparam logic [1:0] DST_FD     = 2'd1;
  localparam logic [1:0] DST_SCHOOL = 2'd2;
  localparam logic [1:0] DST_RIBS   = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4
//   Combinational 4-way round-robin arbiter.
//   Ports:
//     req_i    [3:0]  request vector
//     ptr_i    [1:0]  index of the most recent winner (lowest priority)
//     valid_o         at least one request is set
//     winner_o [1:0]  first set request after ptr_i, modulo 4
module rr_arbiter4
  import internet_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       valid_o,
  output logic [1:0] winner_o
);

  logic       valid_s;
  logic [1:0] winner_s;
  logic [1:0] idx_s;

  // Priority search: scan offsets 4..1 so the nearest offset after ptr_i is
  // written last and therefore wins. Offset 4 is ptr_i itself (lowest priority).
  always_comb begin
    valid_s  = 1'b0;
    winner_s = ptr_i;
    idx_s    = ptr_i;
    for (int i = 4; i >= 1; i--) begin
      idx_s    = ptr_i + 2'(i);
      valid_s  = valid_s | req_i[idx_s];
      winner_s = req_i[idx_s] ? idx_s : winner_s;
    end
  end

  assign valid_o  = valid_s;
  assign winner_o = winner_s;

endmodule

// File: rtl/internet_scheduler.sv
// internet_scheduler
//   Time-shares the 4-bit internet link among Lib, FD, School and Ribs.
//   Round-robin arbitration, bounded slots of SLOT_CYCLES, one-cycle guard
//   gap between slots. All outputs are registered (Moore).
//   Ports:
//     clk        system clock
//     reset      synchronous, active-high
//     req  [3:0] per-destination request ([0]=Lib [1]=FD [2]=School [3]=Ribs)
//     Enable     internet_demux Enable, high only while granting
//     Sel  [1:0] internet_demux Sel, current / last grantee
//     grant[3:0] one-hot current grantee, zero outside a slot
//     slot_left  cycles remaining in current slot, zero outside a slot
module internet_scheduler
  import internet_pkg::*;
#(
  parameter int SLOT_CYCLES = 8,
  localparam int CNT_W      = $clog2(SLOT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  output logic             Enable,
  output logic [1:0]       Sel,
  output logic [3:0]       grant,
  output logic [CNT_W-1:0] slot_left
);

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       sel_q;
  logic             enable_q;
  logic [3:0]       grant_q;
  logic [CNT_W-1:0] slot_left_q;

  logic             arb_valid_s;
  logic [1:0]       arb_winner_s;

  rr_arbiter4 u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid_s),
    .winner_o (arb_winner_s)
  );

  // Scheduler FSM: state, RR pointer, slot counter and registered demux controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= DST_RIBS;  // Lib is first after Ribs
      sel_q       <= DST_LIB;
      enable_q    <= 1'b0;
      grant_q     <= 4'b0000;
      slot_left_q <= '0;
    end else begin
      case (state_q)
        IDLE, GUARD: begin
          if (arb_valid_s) begin
            state_q     <= GRANT;
            ptr_q       <= arb_winner_s;
            sel_q       <= arb_winner_s;  // Sel only moves here, with Enable low
            enable_q    <= 1'b1;
            grant_q     <= onehot4(arb_winner_s);
            slot_left_q <= CNT_W'(SLOT_CYCLES);
          end else begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            grant_q     <= 4'b0000;
            slot_left_q <= '0;
          end
        end
        GRANT: begin
          // Expiry and early release share one exit, so a coincident pair
          // cannot produce two transitions. Exit at 1 keeps the counter from
          // ever wrapping.
          if ((slot_left_q == CNT_W'(1)) || !req[sel_q]) begin
            state_q     <= GUARD;
            enable_q    <= 1'b0;
            grant_q     <= 4'b0000;
            slot_left_q <= '0;
          end else begin
            state_q     <= GRANT;
            slot_left_q <= slot_left_q - CNT_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          enable_q    <= 1'b0;
          grant_q     <= 4'b0000;
          slot_left_q <= '0;
        end
      endcase
    end
  end

  assign Enable    = enable_q;
  assign Sel       = sel_q;
  assign grant     = grant_q;
  assign slot_left = slot_left_q;

endmodule

// File: tb/tb_internet_scheduler.sv
// tb_internet_scheduler
//   Directed bench for internet_scheduler: one instance with SLOT_CYCLES=4,
//   one with SLOT_CYCLES=1. Outputs are sampled on the falling edge.
module tb_internet_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] req4;
  logic [3:0] req1;

  logic       en4;
  logic [1:0] sel4;
  logic [3:0] grant4;
  logic [2:0] slot4;

  logic       en1;
  logic [1:0] sel1;
  logic [3:0] grant1;
  logic [0:0] slot1;

  int n_checks;
  int n_errors;

  internet_scheduler #(.SLOT_CYCLES(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .req       (req4),
    .Enable    (en4),
    .Sel       (sel4),
    .grant     (grant4),
    .slot_left (slot4)
  );

  internet_scheduler #(.SLOT_CYCLES(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req       (req1),
    .Enable    (en1),
    .Sel       (sel1),
    .grant     (grant1),
    .slot_left (slot1)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect4(input string tag, input logic en, input logic [1:0] sel,
                         input logic [3:0] gr, input logic [2:0] sl);
    check_val({tag, ".en"},    32'(en4),    32'(en));
    check_val({tag, ".sel"},   32'(sel4),   32'(sel));
    check_val({tag, ".grant"}, 32'(grant4), 32'(gr));
    check_val({tag, ".slot"},  32'(slot4),  32'(sl));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Directed stimulus with hand-derived expectations.
  initial begin
    logic [1:0] es;
    logic       ee;
    logic       prev_en;
    logic [1:0] prev_sel;
    int         ph;

    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    req4     = 4'b0000;
    req1     = 4'b0000;

    // 1: reset state, then idle with no requests
    do_reset();
    expect4("t1_rst", 1'b0, 2'd0, 4'b0000, 3'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect4("t1_idle", 1'b0, 2'd0, 4'b0000, 3'd0);
      check_val("t1_idle1.en", 32'(en1), 32'd0);
    end

    // 2: all request -> Lib, FD, School, Ribs, Lib; 4 enable + 1 guard each
    do_reset();
    req4 = 4'b1111;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      es = 2'((i / 5) % 4);
      ph = i % 5;
      if (ph < 4) expect4("t2_grant", 1'b1, es, 4'(1 << es), 3'(4 - ph));
      else        expect4("t2_guard", 1'b0, es, 4'b0000, 3'd0);
    end

    // 3: Lib alone -> 11110 repeating, Sel steady 0
    do_reset();
    req4 = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ph = i % 5;
      if (ph < 4) expect4("t3_grant", 1'b1, 2'd0, 4'b0001, 3'(4 - ph));
      else        expect4("t3_guard", 1'b0, 2'd0, 4'b0000, 3'd0);
    end

    // 4: FD early release after 2 cycles, Ribs next
    do_reset();
    req4 = 4'b0010;
    @(negedge clk); expect4("t4_fd0", 1'b1, 2'd1, 4'b0010, 3'd4);
    @(negedge clk); expect4("t4_fd1", 1'b1, 2'd1, 4'b0010, 3'd3);
    req4 = 4'b1000;
    @(negedge clk); expect4("t4_guard", 1'b0, 2'd1, 4'b0000, 3'd0);
    @(negedge clk); expect4("t4_ribs", 1'b1, 2'd3, 4'b1000, 3'd4);

    // 5: reset mid-slot (School, slot_left=2), then Lib first
    do_reset();
    req4 = 4'b0100;
    @(negedge clk); expect4("t5_s0", 1'b1, 2'd2, 4'b0100, 3'd4);
    @(negedge clk); expect4("t5_s1", 1'b1, 2'd2, 4'b0100, 3'd3);
    @(negedge clk); expect4("t5_s2", 1'b1, 2'd2, 4'b0100, 3'd2);
    reset = 1'b1;
    req4  = 4'b1111;
    @(negedge clk); expect4("t5_rst", 1'b0, 2'd0, 4'b0000, 3'd0);
    reset = 1'b0;
    @(negedge clk); expect4("t5_lib", 1'b1, 2'd0, 4'b0001, 3'd4);
    req4 = 4'b0000;

    // 6: SLOT_CYCLES=1, FD+School -> FD, School, FD, School, 50% duty
    do_reset();
    req1     = 4'b0110;
    prev_en  = 1'b0;
    prev_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      es = ((i / 2) % 2 == 0) ? 2'd1 : 2'd2;
      ee = (i % 2 == 0);
      check_val("t6.en",    32'(en1),    32'(ee));
      check_val("t6.sel",   32'(sel1),   32'(es));
      check_val("t6.grant", 32'(grant1), ee ? 32'(1 << es) : 32'd0);
      check_val("t6.slot",  32'(slot1),  ee ? 32'd1 : 32'd0);
      if (prev_en && en1) check_val("t6.sel_stable", 32'(sel1), 32'(prev_sel));
      prev_en  = en1;
      prev_sel = sel1;
    end
    req1 = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
